// File: rtl/regbank_pkg.sv
// Shared constants and types for the 16x16 register bank.
// State encoding is kept as plain localparams for legacy tool compatibility.
// Counter type sized to walk all sixteen registers during a clear.
package regbank_pkg;

  localparam int WIDTH = 16;
  localparam int NREGS = 16;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_CLEAR = 1'b1;

  typedef logic [3:0] cnt_t;

endpackage

// File: rtl/onehot_dec4.sv
// 4-to-16 one-hot decoder with enable.
// Latency: combinational, zero cycles.
// Backpressure: none; output is all-zero when en is low.
module onehot_dec4 (
  input  logic [3:0]  idx,
  input  logic        en,
  output logic [15:0] onehot
);

  // Single set bit at position idx, or nothing when disabled.
  always_comb begin
    onehot = 16'h0000;
    if (en) onehot[idx] = 1'b1;
  end

endmodule

// File: rtl/reg_bank_16.sv
// Sixteen 16-bit registers with write port, registered one-hot read select and sequential clear.
// Latency: write and read-select take effect one edge after sampling; a clear walks one register per edge over 16 edges.
// Backpressure: busy is high during a clear, while writes, reads and further clear pulses are ignored.
// Build option REGBANK_R0_ZERO_EN: hardwires register 0 to zero.
module reg_bank_16
  import regbank_pkg::*;
#(
  parameter int WIDTH = regbank_pkg::WIDTH,
  parameter int NREGS = regbank_pkg::NREGS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [3:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [3:0]       rd_addr,
  input  logic             clr,
  output logic [WIDTH-1:0] r0,
  output logic [WIDTH-1:0] r1,
  output logic [WIDTH-1:0] r2,
  output logic [WIDTH-1:0] r3,
  output logic [WIDTH-1:0] r4,
  output logic [WIDTH-1:0] r5,
  output logic [WIDTH-1:0] r6,
  output logic [WIDTH-1:0] r7,
  output logic [WIDTH-1:0] r8,
  output logic [WIDTH-1:0] r9,
  output logic [WIDTH-1:0] r10,
  output logic [WIDTH-1:0] r11,
  output logic [WIDTH-1:0] r12,
  output logic [WIDTH-1:0] r13,
  output logic [WIDTH-1:0] r14,
  output logic [WIDTH-1:0] r15,
  output logic [NREGS-1:0] read,
  output logic             busy
);

  logic [WIDTH-1:0] regs [NREGS];
  state_t           state;
  cnt_t             cnt;
  logic [15:0]      wr_dec;
  logic [15:0]      wr_sel;
  logic [15:0]      rd_sel;

  onehot_dec4 u_wr_dec (
    .idx    (wr_addr),
    .en     (wr_en),
    .onehot (wr_dec)
  );

  onehot_dec4 u_rd_dec (
    .idx    (rd_addr),
    .en     (rd_en),
    .onehot (rd_sel)
  );

`ifdef REGBANK_R0_ZERO_EN
  // Register 0 never accepts a write, so it stays at its reset value of zero.
  assign wr_sel = wr_dec & 16'hFFFE;
`else
  assign wr_sel = wr_dec;
`endif

  // Register file, clear engine and read-select pipeline share one state machine.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
      read  <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clr) begin
            // clr wins over a same-edge write; the bus is released while clearing.
            state <= ST_CLEAR;
            busy  <= 1'b1;
            cnt   <= '0;
            read  <= '0;
          end else begin
            read <= rd_sel;
            for (int i = 0; i < NREGS; i++) begin
              if (wr_sel[i]) regs[i] <= wr_data;
            end
          end
        end
        ST_CLEAR: begin
          regs[cnt] <= '0;
          cnt       <= cnt + 4'd1;
          read      <= '0;
          if (cnt == 4'd15) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
          read  <= '0;
        end
      endcase
    end
  end

  assign r0  = regs[0];
  assign r1  = regs[1];
  assign r2  = regs[2];
  assign r3  = regs[3];
  assign r4  = regs[4];
  assign r5  = regs[5];
  assign r6  = regs[6];
  assign r7  = regs[7];
  assign r8  = regs[8];
  assign r9  = regs[9];
  assign r10 = regs[10];
  assign r11 = regs[11];
  assign r12 = regs[12];
  assign r13 = regs[13];
  assign r14 = regs[14];
  assign r15 = regs[15];

endmodule
